// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: FSM states, write-back
// source encodings and the MEM/WB bundle.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    // 2'b11 is reserved and falls back to the ALU result.
    function automatic logic [31:0] wb_select(
        input logic [1:0]  mtr,
        input logic [31:0] alu,
        input logic [31:0] mem,
        input logic [31:0] pc4
    );
        logic [31:0] r;
        r = alu;
        unique case (mtr)
            MTR_MEM: r = mem;
            MTR_PC4: r = pc4;
            default: r = alu;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with stall bubble and fault squash.
// Ports: clk, reset (async, high), stall, squash, wb_in, wb_out.
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic squash,
    input  wb_t  wb_in,
    output wb_t  wb_out
);

    // While stalled only the write enable drops; rd/data hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_out <= '0;
        end else if (stall) begin
            wb_out.reg_write <= 1'b0;
        end else begin
            wb_out <= '{
                reg_write: wb_in.reg_write & ~squash,
                rd:        wb_in.rd,
                data:      wb_in.data
            };
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the valid/ready data-memory port, stalls
// upstream while an access is in flight, and feeds MEM/WB.
// Ports: EX/MEM bundle in (MEM_*), dmem_req_* / dmem_resp_*,
// mem_stall, mem_fault, WB_* registered write-back controls.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MEM_PCplus4,
    input  logic [31:0] MEM_ALU_out,
    input  logic [4:0]  MEM_Write_register,
    input  logic [31:0] MEM_Databus2,
    input  logic        MEM_RegWrite,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_MemtoReg,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_resp_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        WB_RegWrite,
    output logic [4:0]  WB_Write_register,
    output logic [31:0] WB_Write_data
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op;
    logic             bad;
    logic             last;
    logic             req;
    logic             stall;
    logic             fault_now;
    wb_t              wb_in;
    wb_t              wb_out;

    assign op  = MEM_MemRead | MEM_MemWrite;
    assign bad = (MEM_MemRead & MEM_MemWrite)
               | (op & (MEM_ALU_out[1:0] != 2'b00));

    // Abort on the cycle the count would reach TIMEOUT_CYCLES-1.
    assign last = (cnt == CNT_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == S_IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        stall     = 1'b0;
        fault_now = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bad) begin
                    fault_now = 1'b1;
                end else if (op) begin
                    req = 1'b1;
                    if (!dmem_req_ready) begin
                        stall     = 1'b1;
                        state_nxt = S_REQ;
                    end else if (!MEM_MemWrite) begin
                        stall     = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_REQ: begin
                req = 1'b1;
                if (dmem_req_ready && MEM_MemWrite) begin
                    state_nxt = S_IDLE;
                end else if (last) begin
                    fault_now = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stall = 1'b1;
                    if (dmem_req_ready) begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_resp_valid) begin
                    state_nxt = S_IDLE;
                end else if (last) begin
                    fault_now = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset must drop the request and release upstream at once.
    assign dmem_req_valid = req & ~reset;
    assign mem_stall      = stall & ~reset;
    assign dmem_req_we    = MEM_MemWrite;
    assign dmem_req_addr  = MEM_ALU_out;
    assign dmem_req_wdata = MEM_Databus2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_fault <= 1'b0;
        end else begin
            mem_fault <= fault_now;
        end
    end

    assign wb_in = '{
        reg_write: MEM_RegWrite,
        rd:        MEM_Write_register,
        data:      wb_select(MEM_MemtoReg, MEM_ALU_out,
                             dmem_resp_rdata, MEM_PCplus4)
    };

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .reset  (reset),
        .stall  (stall),
        .squash (fault_now),
        .wb_in  (wb_in),
        .wb_out (wb_out)
    );

    assign WB_RegWrite       = wb_out.reg_write;
    assign WB_Write_register = wb_out.rd;
    assign WB_Write_data     = wb_out.data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a write-back
// scoreboard; runs with TIMEOUT_CYCLES=8.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MEM_PCplus4;
    logic [31:0] MEM_ALU_out;
    logic [4:0]  MEM_Write_register;
    logic [31:0] MEM_Databus2;
    logic        MEM_RegWrite;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [1:0]  MEM_MemtoReg;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        mem_stall;
    logic        mem_fault;
    logic        WB_RegWrite;
    logic [4:0]  WB_Write_register;
    logic [31:0] WB_Write_data;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .MEM_PCplus4        (MEM_PCplus4),
        .MEM_ALU_out        (MEM_ALU_out),
        .MEM_Write_register (MEM_Write_register),
        .MEM_Databus2       (MEM_Databus2),
        .MEM_RegWrite       (MEM_RegWrite),
        .MEM_MemRead        (MEM_MemRead),
        .MEM_MemWrite       (MEM_MemWrite),
        .MEM_MemtoReg       (MEM_MemtoReg),
        .dmem_req_valid     (dmem_req_valid),
        .dmem_req_ready     (dmem_req_ready),
        .dmem_req_we        (dmem_req_we),
        .dmem_req_addr      (dmem_req_addr),
        .dmem_req_wdata     (dmem_req_wdata),
        .dmem_resp_valid    (dmem_resp_valid),
        .dmem_resp_rdata    (dmem_resp_rdata),
        .mem_stall          (mem_stall),
        .mem_fault          (mem_fault),
        .WB_RegWrite        (WB_RegWrite),
        .WB_Write_register  (WB_Write_register),
        .WB_Write_data      (WB_Write_data)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic        rd_en,
                         input logic        wr_en,
                         input logic        rw,
                         input logic [1:0]  mtr,
                         input logic [4:0]  rd,
                         input logic [31:0] alu,
                         input logic [31:0] wdata,
                         input logic [31:0] pc4);
        MEM_MemRead        = rd_en;
        MEM_MemWrite       = wr_en;
        MEM_RegWrite       = rw;
        MEM_MemtoReg       = mtr;
        MEM_Write_register = rd;
        MEM_ALU_out        = alu;
        MEM_Databus2       = wdata;
        MEM_PCplus4        = pc4;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, MTR_ALU, 5'd31,
              32'hFFFF_0000, 32'h0, 32'h0);
    endtask

    // Every write-back the DUT commits must match the oldest
    // expectation, and none may appear unannounced.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && WB_RegWrite === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_bad++;
                $error("FAIL wb_unexpected: rd %0d data %h",
                       WB_Write_register, WB_Write_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wb_rd", 32'(WB_Write_register), 32'(e.rd));
                check("wb_data", WB_Write_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset           = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0BAD_BAD0;
        // A load sits on the inputs during reset.
        drive(1'b1, 1'b0, 1'b1, MTR_MEM, 5'd3,
              32'h40, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_fault", 32'(mem_fault), 32'd0);
        check("rst_wb_we", 32'(WB_RegWrite), 32'd0);
        check("rst_wb_rd", 32'(WB_Write_register), 32'd0);
        check("rst_wb_data", WB_Write_data, 32'd0);
        tick();
        nop();
        reset = 1'b0;
        @(negedge clk);
        check("idle_stall", 32'(mem_stall), 32'd0);

        // ALU ops, including PC+4 and reserved selects.
        tick();
        drive(1'b0, 1'b0, 1'b1, MTR_ALU, 5'd5,
              32'h1234, 32'h0, 32'h100);
        sb.push_back('{5'd5, 32'h1234});
        @(negedge clk);
        check("t1_stall", 32'(mem_stall), 32'd0);
        check("t1_valid", 32'(dmem_req_valid), 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, MTR_PC4, 5'd9,
              32'h55, 32'h0, 32'h104);
        sb.push_back('{5'd9, 32'h104});
        @(negedge clk);
        check("t1_wb_we", 32'(WB_RegWrite), 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b1, 2'b11, 5'd10,
              32'h77, 32'h0, 32'h108);
        sb.push_back('{5'd10, 32'h77});
        tick();
        nop();
        @(negedge clk);

        // Load accepted at once, response three cycles on.
        tick();
        dmem_req_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, MTR_MEM, 5'd6,
              32'h40, 32'h0, 32'h200);
        @(negedge clk);
        check("t2_valid", 32'(dmem_req_valid), 32'd1);
        check("t2_we", 32'(dmem_req_we), 32'd0);
        check("t2_addr", dmem_req_addr, 32'h40);
        check("t2_stall0", 32'(mem_stall), 32'd1);
        tick();
        dmem_req_ready = 1'b0;
        @(negedge clk);
        check("t2_stall1", 32'(mem_stall), 32'd1);
        check("t2_valid1", 32'(dmem_req_valid), 32'd0);
        check("t2_bubble1", 32'(WB_RegWrite), 32'd0);
        tick();
        @(negedge clk);
        check("t2_stall2", 32'(mem_stall), 32'd1);
        check("t2_bubble2", 32'(WB_RegWrite), 32'd0);
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hDEAD_BEEF;
        sb.push_back('{5'd6, 32'hDEAD_BEEF});
        @(negedge clk);
        check("t2_stall3", 32'(mem_stall), 32'd0);
        check("t2_bubble3", 32'(WB_RegWrite), 32'd0);
        tick();
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0BAD_BAD0;
        nop();
        @(negedge clk);
        check("t2_wb_we", 32'(WB_RegWrite), 32'd1);
        tick();
        @(negedge clk);
        check("t2_wb_once", 32'(WB_RegWrite), 32'd0);

        // Store held off by ready for two cycles.
        tick();
        dmem_req_ready = 1'b0;
        drive(1'b0, 1'b1, 1'b0, MTR_ALU, 5'd0,
              32'h80, 32'hCAFE, 32'h0);
        @(negedge clk);
        check("t3_valid0", 32'(dmem_req_valid), 32'd1);
        check("t3_we", 32'(dmem_req_we), 32'd1);
        check("t3_addr", dmem_req_addr, 32'h80);
        check("t3_wdata", dmem_req_wdata, 32'hCAFE);
        check("t3_stall0", 32'(mem_stall), 32'd1);
        tick();
        @(negedge clk);
        check("t3_valid1", 32'(dmem_req_valid), 32'd1);
        check("t3_stall1", 32'(mem_stall), 32'd1);
        tick();
        dmem_req_ready = 1'b1;
        @(negedge clk);
        check("t3_valid2", 32'(dmem_req_valid), 32'd1);
        check("t3_stall2", 32'(mem_stall), 32'd0);
        tick();
        dmem_req_ready = 1'b0;
        nop();
        @(negedge clk);
        check("t3_valid3", 32'(dmem_req_valid), 32'd0);
        check("t3_fault", 32'(mem_fault), 32'd0);

        // Misaligned load, then load+store together.
        tick();
        drive(1'b1, 1'b0, 1'b1, MTR_MEM, 5'd7,
              32'h41, 32'h0, 32'h0);
        @(negedge clk);
        check("t4_valid", 32'(dmem_req_valid), 32'd0);
        check("t4_stall", 32'(mem_stall), 32'd0);
        check("t4_fault0", 32'(mem_fault), 32'd0);
        tick();
        nop();
        @(negedge clk);
        check("t4_fault1", 32'(mem_fault), 32'd1);
        check("t4_wb_we", 32'(WB_RegWrite), 32'd0);
        tick();
        @(negedge clk);
        check("t4_fault2", 32'(mem_fault), 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b1, MTR_ALU, 5'd8,
              32'h50, 32'h0, 32'h0);
        @(negedge clk);
        check("t4b_valid", 32'(dmem_req_valid), 32'd0);
        tick();
        nop();
        @(negedge clk);
        check("t4b_fault", 32'(mem_fault), 32'd1);
        check("t4b_wb_we", 32'(WB_RegWrite), 32'd0);
        tick();
        @(negedge clk);
        check("t4b_fault2", 32'(mem_fault), 32'd0);

        // Load whose response never comes.
        tick();
        dmem_req_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, MTR_MEM, 5'd11,
              32'h44, 32'h0, 32'h0);
        n = 0;
        @(negedge clk);
        while (mem_stall === 1'b1 && n < 40) begin
            n++;
            tick();
            dmem_req_ready = 1'b0;
            @(negedge clk);
        end
        check("t5_stall_cycles", 32'(n), 32'd7);
        check("t5_fault0", 32'(mem_fault), 32'd0);
        tick();
        nop();
        @(negedge clk);
        check("t5_fault1", 32'(mem_fault), 32'd1);
        check("t5_wb_we", 32'(WB_RegWrite), 32'd0);
        tick();
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h1111_1111;
        @(negedge clk);
        check("t5_late_stall", 32'(mem_stall), 32'd0);
        check("t5_fault2", 32'(mem_fault), 32'd0);
        tick();
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0BAD_BAD0;
        @(negedge clk);
        check("t5_late_fault", 32'(mem_fault), 32'd0);
        check("t5_late_wb", 32'(WB_RegWrite), 32'd0);

        // Reset while waiting for a response.
        tick();
        dmem_req_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, MTR_MEM, 5'd13,
              32'h48, 32'h0, 32'h0);
        @(negedge clk);
        check("t6_stall0", 32'(mem_stall), 32'd1);
        tick();
        dmem_req_ready = 1'b0;
        @(negedge clk);
        check("t6_stall1", 32'(mem_stall), 32'd1);
        check("t6_wb_hold", 32'(WB_Write_register), 32'd31);
        #1;
        reset = 1'b1;
        #1;
        check("t6_rst_stall", 32'(mem_stall), 32'd0);
        check("t6_rst_valid", 32'(dmem_req_valid), 32'd0);
        check("t6_rst_wb_rd", 32'(WB_Write_register), 32'd0);
        check("t6_rst_wb_data", WB_Write_data, 32'd0);
        tick();
        nop();
        reset = 1'b0;
        @(negedge clk);
        check("t6_idle", 32'(mem_stall), 32'd0);
        tick();
        dmem_req_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, MTR_MEM, 5'd14,
              32'h4C, 32'h0, 32'h0);
        @(negedge clk);
        check("t6_ld_valid", 32'(dmem_req_valid), 32'd1);
        check("t6_ld_stall", 32'(mem_stall), 32'd1);
        tick();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h600D_F00D;
        sb.push_back('{5'd14, 32'h600D_F00D});
        @(negedge clk);
        check("t6_ld_done", 32'(mem_stall), 32'd0);
        tick();
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0BAD_BAD0;
        nop();
        @(negedge clk);
        check("t6_wb_we", 32'(WB_RegWrite), 32'd1);
        tick();
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
